// File: rtl/frame_downloader.sv
// Fetches a stored frame from PSRAM in bursts and serialises it into the
// 17-bit display queue: SOF, per-row SOR, pixels, EOF markers.
// Ports: clk/reset; start+base_addr kick off a frame;
// read_rq/read_ack/read_addr/mem_rd_en/read_data/data_valid talk to memory;
// queue_data/wr_en/queue_full feed the video FIFO; download_done pulses at end.
module frame_downloader #(
  parameter int MEMORY_BURST = 32,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int TCMD         = 19
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [20:0] base_addr,
  input  logic        read_ack,
  input  logic [31:0] read_data,
  input  logic        data_valid,
  input  logic        queue_full,
  output logic        read_rq,
  output logic [20:0] read_addr,
  output logic        mem_rd_en,
  output logic [16:0] queue_data,
  output logic        wr_en,
  output logic        download_done
);

  localparam int BURST_PX = MEMORY_BURST / 2;
  localparam int NW       = MEMORY_BURST / 4;
  localparam int WIW      = $clog2(NW);

  typedef enum logic [3:0] {
    S_IDLE, S_EMIT_FS, S_ROW_CHECK, S_EMIT_RS,
    S_REQ_WAIT, S_READ_CMD, S_CAPTURE, S_FINISH,
    S_DRAIN, S_COL_CHECK, S_EMIT_FE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [20:0]     addr_q, addr_d;
  logic [20:0]     raddr_q, raddr_d;
  logic [10:0]     row_q, row_d;
  logic [10:0]     col_q, col_d;
  logic [4:0]      burst_q, burst_d;
  logic [7:0]      cyc_q, cyc_d;
  logic [WIW-1:0]  widx_q, widx_d;
  logic [4:0]      px_q, px_d;
  logic [31:0]     buf_q [NW];
  logic            cap_we;

  logic [10:0] rem;
  logic [4:0]  bpx;
  logic [7:0]  cyc_inc;
  logic [31:0] word;
  logic [15:0] half;

  // pixels left in the row, clipped to one burst
  assign rem = 11'(FRAME_WIDTH) - col_q;
  assign bpx = (rem >= 11'(BURST_PX)) ? 5'(BURST_PX) : rem[4:0];
  // saturate so a very slow memory cannot wrap the TCMD guard
  assign cyc_inc = (cyc_q == 8'hFF) ? cyc_q : cyc_q + 8'd1;
  assign word = buf_q[px_q[WIW:1]];
  assign half = px_q[0] ? word[31:16] : word[15:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      raddr_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      burst_q <= '0;
      cyc_q   <= '0;
      widx_q  <= '0;
      px_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      raddr_q <= raddr_d;
      row_q   <= row_d;
      col_q   <= col_d;
      burst_q <= burst_d;
      cyc_q   <= cyc_d;
      widx_q  <= widx_d;
      px_q    <= px_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_we) buf_q[widx_q] <= read_data;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    raddr_d = raddr_q;
    row_d   = row_q;
    col_d   = col_q;
    burst_d = burst_q;
    cyc_d   = cyc_q;
    widx_d  = widx_q;
    px_d    = px_q;
    cap_we  = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        addr_d  = base_addr;
        row_d   = '0;
        state_d = S_EMIT_FS;
      end
      S_EMIT_FS: if (!queue_full) state_d = S_ROW_CHECK;
      S_ROW_CHECK: begin
        if (row_q == 11'(FRAME_HEIGHT)) begin
          state_d = S_EMIT_FE;
        end else begin
          col_d   = '0;
          state_d = S_EMIT_RS;
        end
      end
      S_EMIT_RS: if (!queue_full) begin
        burst_d = bpx;
        state_d = S_REQ_WAIT;
      end
      S_REQ_WAIT: if (read_ack) begin
        raddr_d = addr_q;
        cyc_d   = '0;
        widx_d  = '0;
        state_d = S_READ_CMD;
      end
      S_READ_CMD: begin
        cyc_d   = cyc_inc;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        cyc_d = cyc_inc;
        if (data_valid) begin
          cap_we = 1'b1;
          widx_d = widx_q + 1'b1;
          if (widx_q == WIW'(NW - 1)) state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        cyc_d = cyc_inc;
        if (cyc_q >= 8'(TCMD)) begin
          px_d    = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (!queue_full) begin
        px_d = px_q + 5'd1;
        if (px_q + 5'd1 == burst_q) begin
          addr_d  = addr_q + 21'(burst_q);
          col_d   = col_q + 11'(burst_q);
          state_d = S_COL_CHECK;
        end
      end
      S_COL_CHECK: begin
        if (col_q >= 11'(FRAME_WIDTH)) begin
          row_d   = row_q + 11'd1;
          state_d = S_ROW_CHECK;
        end else begin
          burst_d = bpx;
          state_d = S_REQ_WAIT;
        end
      end
      S_EMIT_FE: if (!queue_full) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    read_rq       = 1'b0;
    mem_rd_en     = 1'b0;
    wr_en         = 1'b0;
    queue_data    = '0;
    download_done = 1'b0;
    unique case (state_q)
      S_EMIT_FS: begin
        wr_en      = !queue_full;
        queue_data = wr_en ? 17'h10000 : '0;
      end
      S_EMIT_RS: begin
        wr_en      = !queue_full;
        queue_data = wr_en ? 17'h10001 : '0;
      end
      S_REQ_WAIT: read_rq = 1'b1;
      S_READ_CMD: begin
        read_rq   = 1'b1;
        mem_rd_en = 1'b1;
      end
      S_CAPTURE: read_rq = 1'b1;
      S_FINISH:  read_rq = 1'b1;
      S_DRAIN: begin
        wr_en      = !queue_full;
        queue_data = wr_en ? {1'b0, half} : '0;
      end
      S_EMIT_FE: begin
        wr_en      = !queue_full;
        queue_data = wr_en ? 17'h1FFFF : '0;
      end
      S_DONE: download_done = 1'b1;
      default: ;
    endcase
  end

  assign read_addr = raddr_q;

endmodule

// File: tb/tb_frame_downloader.sv
// Directed bench for frame_downloader on a 20x2 frame with a
// behavioural memory/arbiter and queue-full stall injection.
module tb_frame_downloader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [20:0] base_addr;
  logic        read_ack;
  logic [31:0] read_data;
  logic        data_valid;
  logic        queue_full;
  logic        read_rq;
  logic [20:0] read_addr;
  logic        mem_rd_en;
  logic [16:0] queue_data;
  logic        wr_en;
  logic        download_done;

  frame_downloader #(
    .MEMORY_BURST(32),
    .FRAME_WIDTH(20),
    .FRAME_HEIGHT(2),
    .TCMD(19)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .read_ack(read_ack),
    .read_data(read_data),
    .data_valid(data_valid),
    .queue_full(queue_full),
    .read_rq(read_rq),
    .read_addr(read_addr),
    .mem_rd_en(mem_rd_en),
    .queue_data(queue_data),
    .wr_en(wr_en),
    .download_done(download_done)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pix(input logic [20:0] p);
    if (p == 21'h100) return 16'hAAAA;
    if (p == 21'h101) return 16'hBBBB;
    return p[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [31:0] mword(input logic [20:0] a, input int k);
    return {pix(a + 21'(2 * k + 1)), pix(a + 21'(2 * k))};
  endfunction

  // memory / arbiter model
  int mst = 0, mcnt = 0;
  int ack_dly = 2, dv_dly = 3, nvalid = 8;
  logic [20:0] maddr = '0;

  always @(negedge clk) begin
    read_ack   = 1'b0;
    data_valid = 1'b0;
    if (reset) begin
      mst  = 0;
      mcnt = 0;
    end else begin
      case (mst)
        0: if (read_rq) begin
          mcnt++;
          if (mcnt >= ack_dly) begin
            read_ack = 1'b1;
            mcnt = 0;
            mst = 1;
          end
        end
        1: if (mem_rd_en) begin
          maddr = read_addr;
          mcnt = 0;
          mst = 2;
        end
        2: begin
          mcnt++;
          if (mcnt >= dv_dly && mcnt < dv_dly + nvalid) begin
            data_valid = 1'b1;
            read_data = mword(maddr, mcnt - dv_dly);
          end
          if (mcnt >= dv_dly + nvalid) mst = 3;
        end
        default: if (!read_rq) begin
          mcnt = 0;
          mst = 0;
        end
      endcase
    end
  end

  // output monitor
  logic [16:0] got[$];
  logic [20:0] addrs[$];
  int holds[$];
  int pushes = 0, viol = 0, done_cnt = 0, rd_cnt = 0;
  int hold = 0;
  bit in_hold = 0;

  always begin
    @(negedge clk);
    #2;
    if (wr_en) begin
      got.push_back(queue_data);
      pushes++;
      if (queue_full) viol++;
    end
    if (download_done) done_cnt++;
    if (mem_rd_en) begin
      rd_cnt++;
      addrs.push_back(read_addr);
      in_hold = 1;
      hold = 1;
    end else if (in_hold) begin
      if (read_rq) hold++;
      else begin
        holds.push_back(hold);
        in_hold = 0;
      end
    end
  end

  task automatic clear_mon();
    got.delete();
    addrs.delete();
    holds.delete();
    pushes = 0;
    viol = 0;
    done_cnt = 0;
    rd_cnt = 0;
  endtask

  task automatic run_frame(input logic [20:0] base, input int stall_at,
                           input int spur_at);
    int sleft = 0;
    bit stalled = 0, spurred = 0;
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
    base_addr = 21'h1ABCD;
    for (int c = 0; c < 6000 && done_cnt == 0; c++) begin
      @(negedge clk);
      if (stall_at > 0 && pushes == stall_at && !stalled) begin
        queue_full = 1'b1;
        sleft = 10;
        stalled = 1;
      end else if (sleft > 0) begin
        sleft--;
        if (sleft == 0) queue_full = 1'b0;
      end
      if (spur_at > 0 && pushes == spur_at && !spurred) begin
        start = 1'b1;
        base_addr = 21'h300;
        spurred = 1;
      end else begin
        start = 1'b0;
      end
    end
    repeat (5) @(negedge clk);
    queue_full = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_frame(input logic [20:0] base);
    logic [16:0] exp[$];
    int boff[4] = '{0, 16, 20, 36};
    exp.push_back(17'h10000);
    for (int r = 0; r < 2; r++) begin
      exp.push_back(17'h10001);
      for (int c = 0; c < 20; c++)
        exp.push_back({1'b0, pix(base + 21'(r * 20 + c))});
    end
    exp.push_back(17'h1FFFF);
    check("done_cnt", 64'(done_cnt), 64'd1);
    check("npush", 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("push%0d", i), 64'(got[i]), 64'(exp[i]));
    check("full_wr", 64'(viol), 64'd0);
    check("rd_cnt", 64'(rd_cnt), 64'd4);
    for (int b = 0; b < 4 && b < addrs.size(); b++)
      check($sformatf("raddr%0d", b), 64'(addrs[b]),
            64'(base + 21'(boff[b])));
    check("nholds", 64'(holds.size()), 64'd4);
    for (int b = 0; b < holds.size(); b++)
      check($sformatf("hold%0d", b), 64'(holds[b]), 64'd20);
  endtask

  function automatic logic [63:0] outs();
    return 64'({read_rq, mem_rd_en, wr_en, download_done,
                queue_data, read_addr});
  endfunction

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    queue_full = 1'b0;
    read_data = '0;
    read_ack = 1'b0;
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", outs(), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // ideal memory, stall mid-drain, spurious start mid-drain
    ack_dly = 2; dv_dly = 3; nvalid = 8;
    run_frame(21'h100, 5, 12);
    check_frame(21'h100);
    if (got.size() > 3) begin
      check("px0", 64'(got[2]), 64'h0AAAA);
      check("px1", 64'(got[3]), 64'h0BBBB);
    end else begin
      check("px_avail", 64'(got.size()), 64'd44);
    end

    // slow grant, fast data with two surplus strobes
    ack_dly = 50; dv_dly = 1; nvalid = 10;
    run_frame(21'h180, 0, 0);
    check_frame(21'h180);

    // reset during capture of the second burst
    ack_dly = 2; dv_dly = 3; nvalid = 8;
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    base_addr = 21'h100;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2000 && rd_cnt < 2; c++) @(negedge clk);
    check("rd_before_rst", 64'(rd_cnt), 64'd2);
    repeat (4) @(negedge clk);
    check("mid_rq", 64'(read_rq), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_outs", outs(), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(21'h200, 0, 0);
    check_frame(21'h200);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
